// File: rtl/gsel_pkg.sv
// Shared constants and types for the game-select sequencer: FSM encoding,
// the menu index and the fallback mapping used for reset and table misses.
package gsel_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RST    = 3'd1;
   localparam logic [2:0] ST_LOOKUP = 3'd2;
   localparam logic [2:0] ST_LOAD   = 3'd3;
   localparam logic [2:0] ST_SETTLE = 3'd4;
   localparam logic [2:0] ST_ACK    = 3'd5;

   localparam logic [5:0]  MASK_DEFAULT = 6'b111111;
   localparam logic [10:0] IX_DEFAULT   = 11'd0;
   localparam logic [7:0]  MENU_SEL     = 8'd0;

   typedef struct packed {
      logic [5:0]  mask;
      logic [10:0] ix;
   } gsel_entry_t;

endpackage

// File: rtl/gsel_table.sv
// Game index -> C-ROM bank base and address mask. Entries mirror the
// generated ix_c table; anything unknown falls back to the menu mapping.
module gsel_table
   import gsel_pkg::*;
(
   input  logic [7:0]  sel,
   output gsel_entry_t entry
);

   always_comb begin
      entry = '{mask: MASK_DEFAULT, ix: IX_DEFAULT};
      case (sel)
         8'd1:    entry = '{mask: 6'h0F, ix: 11'h010};
         8'd5:    entry = '{mask: 6'h3F, ix: 11'h040};
         8'd7:    entry = '{mask: 6'h1F, ix: 11'h080};
         8'd9:    entry = '{mask: 6'h07, ix: 11'h0C0};
         8'd32:   entry = '{mask: 6'h3F, ix: 11'h200};
         default: entry = '{mask: MASK_DEFAULT, ix: IX_DEFAULT};
      endcase
   end

endmodule

// File: rtl/gsel_ctrl.sv
// Game-select sequencer: holds the game in pseudo-reset, swaps GSEL/MASK/IX
// atomically, lets the new mapping settle, then releases reset and acks.
module gsel_ctrl
   import gsel_pkg::*;
#(
   parameter int RST_CYC    = 24,
   parameter int SETTLE_CYC = 12,
   parameter int CNT_W      = 8
) (
   input  logic        CLK_12M,
   input  logic        nRESET,
   input  logic        SEL_REQ,
   input  logic [7:0]  SEL_IN,
   output logic [7:0]  GSEL,
   output logic [5:0]  MASK,
   output logic [10:0] IX,
   output logic        GAME_nRESET,
   output logic        BUSY,
   output logic        SEL_ACK,
   output logic [2:0]  dbg_state
);

   // SEL_REQ is a one-cycle strobe with no ready: it is always accepted,
   // either consumed in IDLE or parked in the one-deep pending slot.
   logic [2:0]       state, state_nxt;
   logic [7:0]       next_sel;
   logic             pend_valid;
   logic [7:0]       pend_sel;
   logic [CNT_W-1:0] cnt;
   gsel_entry_t      tbl_out, tbl_q;
   logic             req_valid;
   logic [7:0]       req_sel;

   gsel_table u_table (
      .sel   (next_sel),
      .entry (tbl_out)
   );

   assign req_valid = SEL_REQ | pend_valid;
   assign req_sel   = SEL_REQ ? SEL_IN : pend_sel;
   assign dbg_state = state;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (req_valid) state_nxt = (req_sel == GSEL) ? ST_ACK : ST_RST;
         ST_RST:    if (cnt == '0) state_nxt = ST_LOOKUP;
         ST_LOOKUP: state_nxt = ST_LOAD;
         ST_LOAD:   state_nxt = ST_SETTLE;
         ST_SETTLE: if (cnt == '0) state_nxt = ST_ACK;
         ST_ACK:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_12M) begin
      if (!nRESET) begin
         state       <= ST_IDLE;
         next_sel    <= MENU_SEL;
         pend_valid  <= 1'b0;
         pend_sel    <= MENU_SEL;
         cnt         <= '0;
         tbl_q       <= '{mask: MASK_DEFAULT, ix: IX_DEFAULT};
         GSEL        <= MENU_SEL;
         MASK        <= MASK_DEFAULT;
         IX          <= IX_DEFAULT;
         GAME_nRESET <= 1'b0;
         BUSY        <= 1'b0;
         SEL_ACK     <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state == ST_IDLE) begin
            pend_valid <= 1'b0;
            if (req_valid && req_sel != GSEL) next_sel <= req_sel;
         end else if (SEL_REQ) begin
            pend_valid <= 1'b1;
            pend_sel   <= SEL_IN;
         end

         // Counter is loaded on entry to a timed state and runs down to zero.
         if (state_nxt == ST_RST && state != ST_RST)
            cnt <= CNT_W'(RST_CYC - 1);
         else if (state_nxt == ST_SETTLE && state != ST_SETTLE)
            cnt <= CNT_W'(SETTLE_CYC - 1);
         else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);

         if (state == ST_LOOKUP) tbl_q <= tbl_out;

         if (state == ST_LOAD) begin
            GSEL <= next_sel;
            MASK <= tbl_q.mask;
            IX   <= tbl_q.ix;
         end

         // GSEL never changes on an edge leading into IDLE or ACK, so the
         // current value is the right one to gate the release.
         GAME_nRESET <= (state_nxt == ST_IDLE || state_nxt == ST_ACK) && (GSEL != MENU_SEL);
         BUSY        <= (state_nxt != ST_IDLE);
         SEL_ACK     <= (state_nxt == ST_ACK);
      end
   end

endmodule
